uart_tx_framer: RTL



---
 rtl/uart_tx_framer_pkg.sv | 45 ++++
 rtl/uart_tx_framer_if.sv | 22 ++
 rtl/uart_tx_framer_piso.sv | 31 +++
 rtl/uart_tx_framer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_framer_pkg.sv
// Shared types, constants and elaboration-time helpers for the UART transmit framer.
package uart_pkg;

    localparam int PAR_NONE    = 0;
    localparam int PAR_EVEN    = 1;
    localparam int PAR_ODD     = 2;
    localparam int FRAME_W_MAX = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        BREAK   = 2'd2,
        RECOVER = 2'd3
    } tx_state_t;

    function automatic int frame_len(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    function automatic bit params_legal(input int data_w, input int parity,
                                        input int stop_bits, input int ovs);
        bit ok;
        ok = (data_w >= 5) && (data_w <= 9);
        ok = ok && (parity >= PAR_NONE) && (parity <= PAR_ODD);
        ok = ok && ((stop_bits == 1) || (stop_bits == 2));
        ok = ok && (ovs >= 2) && (ovs <= 64);
        ok = ok && (frame_len(data_w, parity, stop_bits) <= FRAME_W_MAX);
        return ok;
    endfunction

    // Data is presented zero-extended to the widest legal word; only data_w bits count.
    function automatic logic parity_bit(input logic [8:0] data, input int data_w, input int parity);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < data_w) begin
                p = p ^ data[i];
            end else begin
                p = p;
            end
        end
        return (parity == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake between the TX FIFO (master) and the framer (slave).
interface uart_tx_framer_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_framer_piso.sv
// Parallel-in serial-out register; load beats shift, LSB is the serial output.
module uart_piso #(
    parameter int W = 11
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ld,
    input  logic         i_sh,
    input  logic         i_fill,
    input  logic [W-1:0] i_din,
    output logic         o_sout
);

    logic [W-1:0] r_sr;

    // Shift register: resets to mark level so the line idles high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '1;
        end else if (i_ld) begin
            r_sr <= i_din;
        end else if (i_sh) begin
            r_sr <= {i_fill, r_sr[W-1:1]};
        end else begin
            r_sr <= r_sr;
        end
    end

    assign o_sout = r_sr[0];

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start/data/parity/stop framing, oversampled bit timing,
// valid/ready byte intake and break generation.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OVS       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_baud_tick,
    input  logic                   i_brk,
    uart_tx_framer_if.slave        s_if,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int FRAME_W = frame_len(DATA_W, PARITY, STOP_BITS);
    localparam int TICK_W  = $clog2(OVS);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);

    generate
        if (!params_legal(DATA_W, PARITY, STOP_BITS, OVS)) begin : g_bad_params
            $error("uart_tx_framer: illegal DATA_W/PARITY/STOP_BITS/OVS combination");
        end
    endgenerate

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [TICK_W-1:0]   r_tick;
    logic [BIT_W-1:0]    r_bit;
    logic                r_busy;
    logic                r_done;

    logic                w_ready;
    logic                w_ld;
    logic                w_sh;
    logic                w_tick_clr;
    logic                w_tick_inc;
    logic                w_bit_clr;
    logic                w_bit_inc;
    logic                w_done_nxt;
    logic                w_sout;
    logic [FRAME_W-1:0]  w_frame;
    logic [FRAME_W-1:0]  w_ld_data;

    assign w_ready       = (r_state == IDLE) & ~i_brk;
    assign s_if.tx_ready = w_ready;

    // Frame image built straight from the bus so the byte is captured at accept.
    always_comb begin
        w_frame          = '1;
        w_frame[0]       = 1'b0;
        w_frame[DATA_W:1] = s_if.tx_data;
        if (PARITY != PAR_NONE) begin
            w_frame[DATA_W+1] = parity_bit(9'(s_if.tx_data), DATA_W, PARITY);
        end else begin
            w_frame[DATA_W+1] = 1'b1;
        end
    end

    // Next-state and datapath controls; the line level always comes from the PISO LSB.
    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_data   = '1;
        w_sh        = 1'b0;
        w_tick_clr  = 1'b0;
        w_tick_inc  = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_brk) begin
                    w_state_nxt = BREAK;
                    w_ld        = 1'b1;
                    w_ld_data   = '0;
                    w_tick_clr  = 1'b1;
                    w_bit_clr   = 1'b1;
                end else if (s_if.tx_valid) begin
                    w_state_nxt = SHIFT;
                    w_ld        = 1'b1;
                    w_ld_data   = w_frame;
                    w_tick_clr  = 1'b1;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (i_baud_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_sh       = 1'b1;
                        w_tick_clr = 1'b1;
                        if (r_bit == FRAME_LAST) begin
                            w_state_nxt = IDLE;
                            w_bit_clr   = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_bit_inc = 1'b1;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            BREAK: begin
                if (!i_brk) begin
                    w_state_nxt = RECOVER;
                    w_ld        = 1'b1;
                    w_ld_data   = '1;
                    w_tick_clr  = 1'b1;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_state_nxt = BREAK;
                end
            end
            RECOVER: begin
                if (i_baud_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_clr = 1'b1;
                        if (r_bit == STOP_LAST) begin
                            w_state_nxt = IDLE;
                            w_bit_clr   = 1'b1;
                        end else begin
                            w_bit_inc = 1'b1;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end else begin
                    w_state_nxt = RECOVER;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ld        = 1'b1;
                w_ld_data   = '1;
                w_tick_clr  = 1'b1;
                w_bit_clr   = 1'b1;
            end
        endcase
    end

    // State, status flags and the done strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Oversample tick and bit counters; cleared on every load and state exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick <= '0;
            r_bit  <= '0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= '0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + TICK_ONE;
            end else begin
                r_tick <= r_tick;
            end
            if (w_bit_clr) begin
                r_bit <= '0;
            end else if (w_bit_inc) begin
                r_bit <= r_bit + BIT_ONE;
            end else begin
                r_bit <= r_bit;
            end
        end
    end

    uart_piso #(
        .W (FRAME_W)
    ) u_piso (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ld    (w_ld),
        .i_sh    (w_sh),
        .i_fill  (1'b1),
        .i_din   (w_ld_data),
        .o_sout  (w_sout)
    );

    assign o_tx   = w_sout;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
